bin_ram: RTL
============

BIN_RAM -- requirements
Module: bin_ram

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, data bits per word (1..32).
REQ-002 The block SHALL have parameter DEPTH, default 8, number of words (2..256, any value, not only powers of two).
REQ-003 The block SHALL derive ADDR_W = ceil(log2(DEPTH)) internally; it is not a port-settable parameter.
REQ-004 CLK  input  1  single clock; all state changes on the rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 CS  input  1  chip select; gates R, W and CLR.
REQ-007 W  input  1  write request.
REQ-008 R  input  1  read request.
REQ-009 CLR  input  1  start a sweep clear of the whole array.
REQ-010 ADDR  input  ADDR_W  word address.
REQ-011 D  input  WIDTH  write data.
REQ-012 O  output  WIDTH  registered read data.
REQ-013 VALID  output  1  one-cycle pulse marking new data on O.
REQ-014 BUSY  output  1  high while the clear sweep runs.

Function
REQ-015 A write SHALL occur when the array is idle and CS&W&(ADDR<DEPTH) at a rising CLK: mem[ADDR] <= D.
REQ-016 A read SHALL be accepted when idle and CS&R; on the next rising edge O <= mem[ADDR] and VALID = 1 for exactly that one cycle (latency 1).
REQ-017 A read with ADDR>=DEPTH SHALL return O = 0 with VALID = 1; a write with ADDR>=DEPTH SHALL be ignored.
REQ-018 O SHALL hold its last value when no read is accepted; VALID SHALL be 0 on those cycles.
REQ-019 CS=0 SHALL suppress R, W and CLR regardless of their levels.
REQ-020 Simultaneous read and write to the same address SHALL return the pre-write (old) data unless BIN_RAM_BYPASS_EN is defined.
REQ-021 Simultaneous read and write to different addresses SHALL both complete in the same cycle.
REQ-022 The FSM SHALL have exactly two states, IDLE and SWEEP.
REQ-023 IDLE->SWEEP on CS&CLR; the sweep pointer starts at 0 and BUSY rises on the same edge.
REQ-024 CLR SHALL take priority over R and W in that cycle; the R and W are dropped.
REQ-025 In SWEEP, one word SHALL be zeroed per cycle, mem[ptr] <= 0 with ptr += 1; the last write is ptr = DEPTH-1, after which the FSM returns to IDLE and BUSY falls. BUSY SHALL be high for exactly DEPTH cycles.
REQ-026 In SWEEP, R, W and CLR SHALL be ignored; VALID stays 0 and O holds.
REQ-027 CLR asserted again on the cycle BUSY falls SHALL start a new sweep.

Reset
REQ-028 RST_N=0 SHALL immediately force all words of mem to 0, and set O=0, VALID=0, BUSY=0, FSM=IDLE and ptr=0, independent of CLK.
REQ-029 Reset during SWEEP SHALL abort the sweep; the array is already fully zeroed by reset.
REQ-030 The first access SHALL be honoured on the first rising CLK after RST_N deasserts.

Configuration
REQ-031 With macro BIN_RAM_BYPASS_EN defined, a same-address simultaneous read and write SHALL return D (write-through) on O with VALID=1.
REQ-032 Without BIN_RAM_BYPASS_EN, that case SHALL return the old contents.
REQ-033 All other behaviour SHALL be identical with and without the macro.

Verification
REQ-034 WIDTH=4, DEPTH=8: write 0xA to addr 3, then read addr 3 -> next cycle O=0xA, VALID=1 for one cycle, then VALID=0 with O held at 0xA.
REQ-035 mem[5]=0x3; same cycle CS=R=W=1, ADDR=5, D=0xC -> O=0x3 without the macro, O=0xC with BIN_RAM_BYPASS_EN; a later read of addr 5 -> 0xC in both builds.
REQ-036 DEPTH=6: write 0xF to addr 7, then read addr 7 -> O=0, VALID=1; addrs 0..5 unchanged.
REQ-037 Fill all 8 words with 0xF; pulse CLR together with W to addr 2 -> BUSY high for exactly 8 cycles, R/W during the sweep ignored, all words read 0 afterwards.
REQ-038 Drop RST_N low mid-sweep and mid-read with CLK stopped -> O=0, VALID=0, BUSY=0 immediately; all words read 0 after release.

Source files
------------

// File: rtl/bin_ram.sv
// Word-addressable RAM with a registered read port and a one-word-per-cycle sweep clear.
// Define BIN_RAM_BYPASS_EN to make a same-cycle read and write return the incoming write data.
module bin_ram #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     CS,
    input  logic                     W,
    input  logic                     R,
    input  logic                     CLR,
    input  logic [$clog2(DEPTH)-1:0] ADDR,
    input  logic [WIDTH-1:0]         D,
    output logic [WIDTH-1:0]         O,
    output logic                     VALID,
    output logic                     BUSY
);
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  o_reg;
    logic [WIDTH-1:0]  rd_data;
    logic              valid_reg;
    logic              idle, addr_ok, clr_go, wr_go, rd_go, sweeping;

    assign idle     = (state_reg == IDLE);
    assign sweeping = (state_reg == SWEEP);
    assign addr_ok  = ({1'b0, ADDR} < (ADDR_W+1)'(DEPTH));
    // CLR wins over R and W in the cycle it is accepted
    assign clr_go   = idle && CS && CLR;
    assign wr_go    = idle && CS && W && !CLR && addr_ok;
    assign rd_go    = idle && CS && R && !CLR;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (clr_go) begin
                    state_next = SWEEP;
                    ptr_next   = '0;
                end
            end
            SWEEP: begin
                if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr_reg + ADDR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    // Each word is its own register so reset can clear the whole array at once
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [WIDTH-1:0] word_reg;
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    word_reg <= '0;
                end else if (sweeping && (ptr_reg == ADDR_W'(gi))) begin
                    word_reg <= '0;
                end else if (wr_go && (ADDR == ADDR_W'(gi))) begin
                    word_reg <= D;
                end
            end
            assign mem[gi] = word_reg;
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        if (addr_ok) begin
`ifdef BIN_RAM_BYPASS_EN
            rd_data = wr_go ? D : mem[ADDR];
`else
            rd_data = mem[ADDR];
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            o_reg     <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= rd_go;
            if (rd_go) begin
                o_reg <= rd_data;
            end
        end
    end

    assign O     = o_reg;
    assign VALID = valid_reg;
    assign BUSY  = sweeping;
endmodule
